// File: rtl/md_pkg.sv
// md_pkg: op encoding, default latencies and FSM state encoding shared by md_ctrl and md_core.
// MD_MADD_EN makes op 7 (MADD) a multiply-length operation.
package md_pkg;
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_MADD  = 3'd7;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  function automatic logic md_is_long(input logic [2:0] op);
`ifdef MD_MADD_EN
    return (op >= MD_MULT && op <= MD_DIVU) || op == MD_MADD;
`else
    return op >= MD_MULT && op <= MD_DIVU;
`endif
  endfunction
endpackage

// File: rtl/md_core.sv
// md_core: combinational multiply/divide datapath producing the 64-bit {HI,LO} result.
// MD_MADD_EN adds signed multiply-accumulate onto the current HI/LO.
module md_core
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);
  logic [63:0] smul, umul, base;
  logic [31:0] ma, mb, mq, mr, sq, sr, uq, ur;
  always_comb begin
    smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    umul = {32'd0, a} * {32'd0, b};
    // signed divide via magnitudes keeps 0x80000000 / -1 well defined
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    mq = ma / mb;
    mr = ma % mb;
    sq = (a[31] ^ b[31]) ? -mq : mq;
    sr = a[31] ? -mr : mr;
    uq = a / b;
    ur = a % b;
`ifdef MD_MADD_EN
    base = op == MD_MADD ? {hi, lo} + smul : {hi, lo};
`else
    base = {hi, lo};
`endif
    res = op == MD_MULT  ? smul :
          op == MD_MULTU ? umul :
          (op == MD_DIV || op == MD_DIVU) && b != '0 ? (op == MD_DIV ? {sr, sq} : {ur, uq}) :
          base;
  end
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply/divide sequencer with fixed-latency busy window and hazard stall.
// MD_MADD_EN enables op 7 (MADD) through md_pkg/md_core.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   p_q, p_d, hl_q, hl_d, res;
  logic          go, launch, done;
  md_core u_core (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hl_q[63:32]),
    .lo  (hl_q[31:0]),
    .res (res)
  );
  always_comb begin
    go      = state_q == ST_IDLE && start && !req;
    launch  = go && md_is_long(op);
    done    = state_q == ST_RUN && cnt_q == CW'(1);
    state_d = launch ? ST_RUN : done ? ST_IDLE : state_q;
    cnt_d   = launch ? ((op == MD_DIV || op == MD_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
              state_q == ST_RUN ? cnt_q - CW'(1) : cnt_q;
    p_d     = launch ? res : p_q;
    hl_d    = done                 ? p_q :
              go && op == MD_MTHI  ? {a, hl_q[31:0]} :
              go && op == MD_MTLO  ? {hl_q[63:32], a} :
              hl_q;
    busy    = state_q == ST_RUN;
    stall   = md_use & (busy | start);
    hi      = hl_q[63:32];
    lo      = hl_q[31:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      hl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      hl_q    <= hl_d;
    end
  end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed plus randomized checks of md_ctrl against a cycle-level behavioural model.
module tb_md_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  logic        clk = 1'b0, reset, start, req, md_use;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, stall;
  int          n_vec = 0, n_err = 0, n_stall = 0, n;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;
  logic        r_s;
  logic [31:0] r_a, r_b;
  int          k;

  md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .req(req),
    .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset) assert (!(busy && start)) else $error("start issued while busy");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_long(input logic [2:0] o);
`ifdef MD_MADD_EN
    return (o >= 3'd1 && o <= 3'd4) || o == 3'd7;
`else
    return o >= 3'd1 && o <= 3'd4;
`endif
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, y, h, l);
    longint          sx = $signed(x);
    longint          sy = $signed(y);
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint          q, r;
    case (o)
      3'd1: return sx * sy;
      3'd2: return ux * uy;
      3'd3: begin
        if (y == 0) return {h, l};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (y == 0) return {h, l};
        q = longint'(ux / uy);
        r = longint'(ux % uy);
        return {r[31:0], q[31:0]};
      end
      3'd7: return {h, l} + sx * sy;
      default: return {h, l};
    endcase
  endfunction

  task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] x, y,
                     input logic r, input logic u);
    start = s; op = o; a = x; b = y; req = r; md_use = u;
    #1;
    check("stall", stall, u & ((m_left > 0) | s));
    if (stall) n_stall++;
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_res;
    end else if (s && !r) begin
      if (is_long(o)) begin
        m_res  = ref_res(o, x, y, m_hi, m_lo);
        m_left = (o == 3'd3 || o == 3'd4) ? DIV_N : MULT_N;
      end else if (o == 3'd5) m_hi = x;
      else if (o == 3'd6) m_lo = x;
    end
    #1;
    check("busy", busy, m_left > 0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    @(negedge clk);
  endtask

  task automatic drain(input logic pulse_req, output int cnt);
    cnt = 0;
    while (busy && cnt < 30) begin
      cnt++;
      cyc(1'b0, 3'd0, 32'd0, 32'd0, pulse_req && cnt == 2, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; req = 1'b0; md_use = 1'b0;
    m_hi = '0; m_lo = '0; m_res = '0; m_left = 0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    n_stall = 0;
    cyc(1'b1, 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
    drain(1'b1, n);
    check("mult_busy_len", n, MULT_N);
    check("mult_stall_len", n_stall, MULT_N + 1);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    cyc(1'b1, 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    drain(1'b0, n);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    cyc(1'b1, 3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    drain(1'b0, n);
    check("div_busy_len", n, DIV_N);
    check("div_hi", hi, 32'h00000001);
    check("div_lo", lo, 32'hFFFFFFFD);

    cyc(1'b1, 3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    drain(1'b0, n);
    check("divz_busy_len", n, DIV_N);
    check("divz_hi", hi, 32'h00000001);
    check("divz_lo", lo, 32'hFFFFFFFD);

    cyc(1'b1, 3'd5, 32'h12345678, 32'd0, 1'b1, 1'b0);
    check("mthi_flush_hi", hi, 32'h00000001);
    cyc(1'b1, 3'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", busy, 0);

    cyc(1'b1, 3'd3, 32'd100, 32'd3, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rstrun_busy", busy, 0);
    check("rstrun_hi", hi, 0);
    check("rstrun_lo", lo, 0);
    m_hi = '0; m_lo = '0; m_left = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rstrun_nocommit_lo", lo, 0);

    cyc(1'b1, 3'd6, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 3'd7, 32'd1, 32'd1, 1'b0, 1'b0);
`ifdef MD_MADD_EN
    drain(1'b0, n);
    check("madd_busy_len", n, MULT_N);
    check("madd_hi", hi, 32'h00000001);
    check("madd_lo", lo, 32'h00000000);
`else
    check("madd_busy", busy, 0);
    check("madd_hi", hi, 32'h00000000);
    check("madd_lo", lo, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 3000; i++) begin
      k   = int'($urandom_range(0, 9));
      r_a = $urandom;
      r_b = k == 0 ? 32'd0 : k == 1 ? 32'hFFFFFFFF : k == 2 ? 32'($urandom_range(1, 20)) : $urandom;
      if (k == 1 && $urandom_range(0, 1) == 1) r_a = 32'h80000000;
      r_s = m_left == 0 && $urandom_range(0, 2) != 0;
      cyc(r_s, 3'($urandom_range(0, 7)), r_a, r_b, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
